// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//
// Shares one single-port synchronous data RAM between pipeline 0, pipeline 1
// and an external loader/debug port.
//   - Dual pipeline access is serialised in program order (p0, then p1) at
//     the cost of one stall cycle.
//   - The external port is served in otherwise idle cycles. A starvation
//     counter forces an external slot, also costing one stall cycle, once
//     the external port has waited STARVE_LIMIT cycles.
//   - Load data is routed back through a 2-bit tag with one cycle of latency.
//     rdata follows mem_rdata during the rvalid cycle and holds afterwards.
//
// Optional feature: define DM_ARB_FWD_EN to enable a same-cycle bypass.
// When p0 stores and p1 loads the same address, the p0 store data is
// forwarded to p1 instead of serialising the two accesses.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   p0_* / p1_*                   pipeline request, write, address, store data
//   p0_rdata/p1_rdata, *_rvalid   load data and its one-cycle valid pulse
//   ext_req/write/addr/wdata      external request (held until ext_ack)
//   ext_ack, ext_rdata            issue pulse, and load data valid the
//                                 cycle after ext_ack
//   stall                         core holds PC, stages and p0/p1 inputs
//                                 next cycle
//   mem_addr/wdata/write, mem_rdata  RAM port (read data one cycle after
//                                 the address)
module dm_port_arbiter #(
    parameter int AW           = 9,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_write,
    input  logic [AW-1:0] p0_maddr,
    input  logic [DW-1:0] p0_wdata,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_write,
    input  logic [AW-1:0] p1_maddr,
    input  logic [DW-1:0] p1_wdata,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_rvalid,
    input  logic          ext_req,
    input  logic          ext_write,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,
    output logic          stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_P1_PEND   = 2'd1;
    localparam logic [1:0] ST_EXT_FORCE = 2'd2;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_P0   = 2'd1;
    localparam logic [1:0] TAG_P1   = 2'd2;
    localparam logic [1:0] TAG_EXT  = 2'd3;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_P0   = 3'd1;
    localparam logic [2:0] SEL_P1   = 3'd2;
    localparam logic [2:0] SEL_P1L  = 3'd3;  // latched p1 request
    localparam logic [2:0] SEL_EXT  = 3'd4;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [1:0]    state_reg, state_next;
    logic          p1l_write_reg;
    logic [AW-1:0] p1l_addr_reg;
    logic [DW-1:0] p1l_wdata_reg;
    logic [1:0]    tag_reg, tag_next;
    logic [7:0]    starve_reg, starve_next;
    logic [AW-1:0] addr_hold_reg;
    logic [DW-1:0] wdata_hold_reg;
    logic [DW-1:0] p0_rdata_reg, p1_rdata_reg, ext_rdata_reg;

    logic [2:0]    sel;
    logic          latch_p1;
    logic          issue_load;

`ifdef DM_ARB_FWD_EN
    logic          fwd_hit;
    logic          fwd_valid_reg;
    logic [DW-1:0] fwd_data_reg;
`endif

    // Issue decision. Everything is gated by rst so that the RAM port and
    // stall are quiet while reset is held, even if requests are still present.
    always_comb begin
        sel        = SEL_NONE;
        state_next = state_reg;
        stall      = 1'b0;
        latch_p1   = 1'b0;
`ifdef DM_ARB_FWD_EN
        fwd_hit    = 1'b0;
`endif
        if (!rst) begin
            if (state_reg == ST_P1_PEND) begin
                sel        = SEL_P1L;
                state_next = ST_RUN;
            end else begin
                state_next = ST_RUN;
                // ">=" rather than "==": the counter keeps counting during
                // P1_PEND and could otherwise step past the limit unnoticed.
                if (state_reg == ST_RUN && ext_req && starve_reg >= LIMIT &&
                    (p0_req || p1_req)) begin
                    sel        = SEL_EXT;
                    stall      = 1'b1;
                    state_next = ST_EXT_FORCE;
                end else if (p0_req && p1_req) begin
                    sel = SEL_P0;
`ifdef DM_ARB_FWD_EN
                    if (p0_write && !p1_write && p0_maddr == p1_maddr) begin
                        fwd_hit = 1'b1;
                    end else begin
                        latch_p1   = 1'b1;
                        stall      = 1'b1;
                        state_next = ST_P1_PEND;
                    end
`else
                    latch_p1   = 1'b1;
                    stall      = 1'b1;
                    state_next = ST_P1_PEND;
`endif
                end else if (p0_req) begin
                    sel = SEL_P0;
                end else if (p1_req) begin
                    sel = SEL_P1;
                end else if (ext_req) begin
                    sel = SEL_EXT;
                end
            end
        end
    end

    // RAM port mux; address and data hold their last value when idle.
    always_comb begin
        mem_addr  = addr_hold_reg;
        mem_wdata = wdata_hold_reg;
        mem_write = 1'b0;
        case (sel)
            SEL_P0: begin
                mem_addr  = p0_maddr;
                mem_wdata = p0_wdata;
                mem_write = p0_write;
            end
            SEL_P1: begin
                mem_addr  = p1_maddr;
                mem_wdata = p1_wdata;
                mem_write = p1_write;
            end
            SEL_P1L: begin
                mem_addr  = p1l_addr_reg;
                mem_wdata = p1l_wdata_reg;
                mem_write = p1l_write_reg;
            end
            SEL_EXT: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_write = ext_write;
            end
            default: ;
        endcase
    end

    assign ext_ack    = (sel == SEL_EXT);
    assign issue_load = (sel != SEL_NONE) && !mem_write;

    always_comb begin
        tag_next = TAG_NONE;
        if (issue_load) begin
            case (sel)
                SEL_P0:          tag_next = TAG_P0;
                SEL_P1, SEL_P1L: tag_next = TAG_P1;
                SEL_EXT:         tag_next = TAG_EXT;
                default:         tag_next = TAG_NONE;
            endcase
        end
    end

    // Saturating wait counter; cleared whenever ext is served or withdrawn.
    always_comb begin
        if (!ext_req || ext_ack)
            starve_next = 8'd0;
        else if (starve_reg != 8'hFF)
            starve_next = starve_reg + 8'd1;
        else
            starve_next = starve_reg;
    end

    // Read-data routing: rdata follows mem_rdata in the rvalid cycle, then
    // the register holds it.
    assign p0_rvalid = (tag_reg == TAG_P0);
    assign p0_rdata  = p0_rvalid ? mem_rdata : p0_rdata_reg;
    assign ext_rdata = (tag_reg == TAG_EXT) ? mem_rdata : ext_rdata_reg;
`ifdef DM_ARB_FWD_EN
    assign p1_rvalid = (tag_reg == TAG_P1) || fwd_valid_reg;
    assign p1_rdata  = fwd_valid_reg ? fwd_data_reg :
                       (tag_reg == TAG_P1) ? mem_rdata : p1_rdata_reg;
`else
    assign p1_rvalid = (tag_reg == TAG_P1);
    assign p1_rdata  = p1_rvalid ? mem_rdata : p1_rdata_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            p1l_write_reg  <= 1'b0;
            p1l_addr_reg   <= '0;
            p1l_wdata_reg  <= '0;
            tag_reg        <= TAG_NONE;
            starve_reg     <= 8'd0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
            p0_rdata_reg   <= '0;
            p1_rdata_reg   <= '0;
            ext_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            tag_reg        <= tag_next;
            starve_reg     <= starve_next;
            addr_hold_reg  <= mem_addr;
            wdata_hold_reg <= mem_wdata;
            p0_rdata_reg   <= p0_rdata;
            p1_rdata_reg   <= p1_rdata;
            ext_rdata_reg  <= ext_rdata;
            if (latch_p1) begin
                p1l_write_reg <= p1_write;
                p1l_addr_reg  <= p1_maddr;
                p1l_wdata_reg <= p1_wdata;
            end
        end
    end

`ifdef DM_ARB_FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid_reg <= 1'b0;
            fwd_data_reg  <= '0;
        end else begin
            fwd_valid_reg <= fwd_hit;
            if (fwd_hit)
                fwd_data_reg <= p0_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_write, p1_req, p1_write;
    logic [AW-1:0] p0_maddr, p1_maddr, ext_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, ext_wdata;
    logic [DW-1:0] p0_rdata, p1_rdata, ext_rdata;
    logic          p0_rvalid, p1_rvalid;
    logic          ext_req, ext_write, ext_ack, stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write;

    dm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_write(p0_write), .p0_maddr(p0_maddr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_write(p1_write), .p1_maddr(p1_maddr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .ext_req(ext_req), .ext_write(ext_write), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, registered read.
    logic [DW-1:0] ram [0:511];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0]    port;   // 1 = p0, 2 = p1
        logic [DW-1:0] data;
        int            when;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req = 0; p0_write = 0; p0_maddr = '0; p0_wdata = '0;
        p1_req = 0; p1_write = 0; p1_maddr = '0; p1_wdata = '0;
        ext_req = 0; ext_write = 0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic expect_rd(input logic [1:0] port, input logic [DW-1:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        e.when = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every p0/p1 load response is matched against the queue.
    always @(negedge clk) begin
        if (!rst && (p0_rvalid || p1_rvalid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("rd cyc=%0d port=%0d data=%h", cyc, p0_rvalid ? 1 : 2,
                         p0_rvalid ? p0_rdata : p1_rdata);
                check("rd_port", p0_rvalid ? 32'd1 : 32'd2, {30'd0, e.port});
                check("rd_data", p0_rvalid ? p0_rdata : p1_rdata, e.data);
                check("rd_cycle", cyc, e.when);
            end
        end
    end

    initial begin
        rst = 1;
        idle();
        #3;
        check("rst_stall", stall, 0);
        check("rst_ack", ext_ack, 0);
        check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("rst_ext_rdata", ext_rdata, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        tick();
        rst = 0;

        // External store of 0xBEEF at 0x012 while pipelines idle.
        ext_req = 1; ext_write = 1; ext_addr = 9'h012; ext_wdata = 16'hBEEF;
        #2;
        check("ext_wr_ack", ext_ack, 1);
        check("ext_wr_we", mem_write, 1);
        check("ext_wr_addr", mem_addr, 9'h012);
        check("ext_wr_stall", stall, 0);
        tick(); idle();
        #2;
        check("ext_ack_pulse", ext_ack, 0);
        check("idle_we", mem_write, 0);
        check("idle_addr_hold", mem_addr, 9'h012);

        // Single p0 load.
        tick();
        p0_req = 1; p0_maddr = 9'h012;
        #2;
        check("single_addr", mem_addr, 9'h012);
        check("single_we", mem_write, 0);
        check("single_stall", stall, 0);
        expect_rd(1, 16'hBEEF);
        tick(); idle();
        #2;
        check("single_stall_next", stall, 0);
        tick();

`ifndef DM_ARB_FWD_EN
        // Dual access: p0 store, p1 load same address.
        p0_req = 1; p0_write = 1; p0_maddr = 9'h020; p0_wdata = 16'h1111;
        p1_req = 1; p1_write = 0; p1_maddr = 9'h020;
        #2;
        check("dual_stall", stall, 1);
        check("dual_we0", mem_write, 1);
        check("dual_addr0", mem_addr, 9'h020);
        check("dual_wdata0", mem_wdata, 16'h1111);
        tick();
        #2;
        check("dual_stall_once", stall, 0);
        check("dual_we1", mem_write, 0);
        check("dual_addr1", mem_addr, 9'h020);
        expect_rd(2, 16'h1111);
        tick(); idle();
        tick();
`else
        // Bypass: p0 store, p1 load same address, no stall.
        p0_req = 1; p0_write = 1; p0_maddr = 9'h020; p0_wdata = 16'h1111;
        p1_req = 1; p1_write = 0; p1_maddr = 9'h020;
        #2;
        check("fwd_stall", stall, 0);
        check("fwd_we", mem_write, 1);
        check("fwd_addr", mem_addr, 9'h020);
        expect_rd(2, 16'h1111);
        tick(); idle();
        #2;
        check("fwd_single_we", mem_write, 0);
        tick();
        p0_req = 1; p0_write = 1; p0_maddr = 9'h040; p0_wdata = 16'h1234;
        p1_req = 1; p1_write = 0; p1_maddr = 9'h040;
        #2;
        check("fwd2_stall", stall, 0);
        expect_rd(2, 16'h1234);
        tick(); idle();
        tick();
`endif

        // Dual store to the same address: p1 lands last.
        p0_req = 1; p0_write = 1; p0_maddr = 9'h030; p0_wdata = 16'hAAAA;
        p1_req = 1; p1_write = 1; p1_maddr = 9'h030; p1_wdata = 16'h5555;
        #2;
        check("dst_stall", stall, 1);
        check("dst_wdata0", mem_wdata, 16'hAAAA);
        tick();
        #2;
        check("dst_we1", mem_write, 1);
        check("dst_wdata1", mem_wdata, 16'h5555);
        tick(); idle();
        p0_req = 1; p0_maddr = 9'h030;
        expect_rd(1, 16'h5555);
        tick(); idle();

        // External load of 0x030.
        ext_req = 1; ext_addr = 9'h030;
        #2;
        check("ext_rd_ack", ext_ack, 1);
        tick(); ext_req = 0;
        #2;
        check("ext_rdata", ext_rdata, 16'h5555);
        tick();
        #2;
        check("ext_rdata_hold", ext_rdata, 16'h5555);

        // Starvation: ext load held against a p0 load every cycle.
        ext_req = 1; ext_write = 0; ext_addr = 9'h012;
        p0_req = 1; p0_write = 0; p0_maddr = 9'h020;
        for (int i = 1; i <= 8; i++) begin
            #2;
            check("starve_wait_ack", ext_ack, 0);
            check("starve_wait_stall", stall, 0);
            expect_rd(1, 16'h1111);
            tick();
        end
        #2;
        check("starve_force_ack", ext_ack, 1);
        check("starve_force_stall", stall, 1);
        check("starve_force_addr", mem_addr, 9'h012);
        tick(); ext_req = 0;
        #2;
        check("starve_p0_slot_stall", stall, 0);
        check("starve_p0_slot_addr", mem_addr, 9'h020);
        check("starve_ext_rdata", ext_rdata, 16'hBEEF);
        expect_rd(1, 16'h1111);
        tick(); idle();
        tick();

        // Drop before ack clears the counter.
        ext_req = 1; ext_addr = 9'h012;
        p0_req = 1; p0_maddr = 9'h020;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("drop_pre_ack", ext_ack, 0);
            expect_rd(1, 16'h1111);
            tick();
        end
        ext_req = 0;
        #2;
        expect_rd(1, 16'h1111);
        tick();
        ext_req = 1;
        for (int i = 0; i < 8; i++) begin
            #2;
            check("drop_restart_wait", ext_ack, 0);
            expect_rd(1, 16'h1111);
            tick();
        end
        #2;
        check("drop_restart_ack", ext_ack, 1);
        tick(); ext_req = 0;
        #2;
        expect_rd(1, 16'h1111);
        tick(); idle();
        tick();

        // Reset while in P1_PEND.
        p0_req = 1; p0_write = 1; p0_maddr = 9'h040; p0_wdata = 16'h9999;
        p1_req = 1; p1_write = 1; p1_maddr = 9'h041; p1_wdata = 16'h7777;
        #2;
        check("pend_stall", stall, 1);
        tick();
        rst = 1;
        #2;
        check("pend_rst_stall", stall, 0);
        check("pend_rst_we", mem_write, 0);
        check("pend_rst_addr", mem_addr, 0);
        check("pend_rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("pend_rst_ext_rdata", ext_rdata, 0);
        tick();
        rst = 0; idle();
        #2;
        check("post_rst_p1_rvalid", p1_rvalid, 0);
        check("post_rst_we", mem_write, 0);
        tick();
        p1_req = 1; p1_maddr = 9'h012;
        #2;
        check("post_rst_run_stall", stall, 0);
        expect_rd(2, 16'hBEEF);
        tick(); idle();
        tick(); tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
